sens_crc_chk: RTL

SENS_CRC_CHK -- requirements
Module: sens_crc_chk

---
 rtl/sens_crc_chk.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sens_crc_chk.sv
// Sensor frame receiver: collects an MSB/LSB measurement word, optionally
// checks a trailing CRC-8 (poly 0x31, init 0x00), with a per-byte timeout.
module sens_crc_chk #(
  parameter logic [15:0] TMO_CYC = 16'd2000,
  parameter bit          CRC_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        start,
  input  logic [7:0]  din,
  input  logic        din_vld,
  output logic        din_rdy,
  output logic [15:0] dout,
  output logic        dout_vld,
  output logic        crc_err,
  output logic        tmo,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  crc;
  logic [7:0]  crc_nxt;
  logic [7:0]  sh_byte;
  logic [2:0]  bit_cnt;
  logic [1:0]  idx;
  logic [15:0] tmo_cnt;
  logic        tmo_p;
  logic        timed_out;
  logic        accept;
  logic        crc_byte;
  logic        fb;

  always_comb begin
    timed_out = (tmo_cnt >= TMO_CYC);
    din_rdy   = (state == S_WAIT) && !timed_out;
    accept    = din_vld && din_rdy && ce;
    crc_byte  = CRC_EN && (idx == 2'd2);
    fb        = crc[7] ^ sh_byte[7];
    crc_nxt   = {crc[6:0], 1'b0} ^ (fb ? 8'h31 : 8'h00);
    dout_vld  = (state == S_DONE);
    busy      = (state != S_IDLE);
    tmo       = tmo_p;
  end

  always_comb begin
    state_nxt = state;
    if (ce) begin
      if (start) begin
        state_nxt = S_WAIT;
      end else begin
        unique case (state)
          S_IDLE:  state_nxt = S_IDLE;
          S_WAIT: begin
            if (timed_out)   state_nxt = S_IDLE;
            else if (accept) state_nxt = crc_byte ? S_DONE : S_SHIFT;
          end
          S_SHIFT: begin
            if (bit_cnt == 3'd7)
              state_nxt = (!CRC_EN && (idx == 2'd2)) ? S_DONE : S_WAIT;
          end
          S_DONE:  state_nxt = S_IDLE;
          default: state_nxt = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc     <= '0;
      sh_byte <= '0;
      bit_cnt <= '0;
      idx     <= '0;
      tmo_cnt <= '0;
      tmo_p   <= 1'b0;
      dout    <= '0;
      crc_err <= 1'b0;
    end else if (ce) begin
      tmo_p <= 1'b0;
      if (start) begin
        crc     <= '0;
        bit_cnt <= '0;
        idx     <= '0;
        tmo_cnt <= '0;
        crc_err <= 1'b0;
      end else begin
        unique case (state)
          S_WAIT: begin
            if (timed_out) begin
              tmo_p <= 1'b1;
            end else if (accept) begin
              tmo_cnt <= '0;
              if (crc_byte) begin
                crc_err <= (din != crc);
              end else begin
                sh_byte <= din;
                bit_cnt <= '0;
                idx     <= idx + 2'd1;
                if (idx == 2'd0) dout[15:8] <= din;
                else             dout[7:0]  <= din;
              end
            end else if (tmo_cnt != '1) begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
          end
          S_SHIFT: begin
            crc     <= crc_nxt;
            sh_byte <= {sh_byte[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
